// File: rtl/wb_bus_pkg.sv
// Shared definitions for the writeback bus arbiter: default widths, the
// source-index encodings inherited from the old writeback selector, and the
// output-register state type.
package wb_bus_pkg;

   localparam int unsigned DEF_DATA_W  = 16;
   localparam int unsigned DEF_NUM_SRC = 6;

   // Same encodings as the original writeback data-select mux.
   localparam int unsigned SRC_ALU   = 0;
   localparam int unsigned SRC_SHIFT = 1;
   localparam int unsigned SRC_IMM   = 2;
   localparam int unsigned SRC_MEM   = 3;
   localparam int unsigned SRC_PC    = 4;
   localparam int unsigned SRC_REGB  = 5;

   typedef logic [2:0] src_idx_t;

   typedef enum logic {
      StEmpty,
      StFull
   } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational request arbiter. Round-robin scans from the supplied pointer
// with wrap-around; fixed priority scans from index 0. The pointer register
// belongs to the parent.
module rr_arbiter #(
   parameter int unsigned NUM_SRC = 6,
   parameter int unsigned RR_MODE = 1,
   parameter int unsigned SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic [NUM_SRC-1:0] i_req,
   input  logic [SRC_W-1:0]   i_rr_ptr,
   output logic [NUM_SRC-1:0] o_gnt,
   output logic [SRC_W-1:0]   o_gnt_idx
);

   logic             w_found;
   logic [SRC_W-1:0] w_idx;

   // First requester at or after the start index wins.
   always_comb begin
      o_gnt     = '0;
      o_gnt_idx = '0;
      w_found   = 1'b0;
      w_idx     = '0;
      for (int k = 0; k < int'(NUM_SRC); k++) begin
         if (RR_MODE != 0) begin
            w_idx = SRC_W'((int'(i_rr_ptr) + k) % int'(NUM_SRC));
         end else begin
            w_idx = SRC_W'(k);
         end
         if (!w_found && i_req[w_idx]) begin
            w_found      = 1'b1;
            o_gnt[w_idx] = 1'b1;
            o_gnt_idx    = w_idx;
         end
      end
   end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Writeback bus arbiter: NUM_SRC valid/ready producers feed a single-entry
// output register that drains into the register-file write port.
// Optional build macro WB_BUS_CONFLICT_CNT_EN adds a saturating 32-bit count
// of loads that had two or more competing requesters.
module wb_bus_arbiter
   import wb_bus_pkg::*;
#(
   parameter int unsigned DATA_W  = DEF_DATA_W,
   parameter int unsigned NUM_SRC = DEF_NUM_SRC,
   parameter int unsigned SRC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
   parameter int unsigned RR_MODE = 1
) (
   input  logic                      i_clk,
   input  logic                      i_reset_n,
   input  logic [NUM_SRC-1:0]        i_src_valid,
   input  logic [NUM_SRC*DATA_W-1:0] i_src_data,
   output logic [NUM_SRC-1:0]        o_src_ready,
   output logic                      o_out_valid,
   output logic [DATA_W-1:0]         o_out_data,
   output logic [SRC_W-1:0]          o_out_src,
   input  logic                      i_out_ready,
`ifdef WB_BUS_CONFLICT_CNT_EN
   output logic [31:0]               o_conflict_cnt,
`endif
   output logic                      o_busy
);

   out_state_e         r_state;
   out_state_e         w_state_next;
   logic [DATA_W-1:0]  r_out_data;
   logic [SRC_W-1:0]   r_out_src;
   logic [SRC_W-1:0]   r_rr_ptr;
   logic [NUM_SRC-1:0] w_gnt;
   logic [SRC_W-1:0]   w_gnt_idx;
   logic               w_any_req;
   logic               w_load;

   rr_arbiter #(
      .NUM_SRC (NUM_SRC),
      .RR_MODE (RR_MODE),
      .SRC_W   (SRC_W)
   ) u_rr_arbiter (
      .i_req     (i_src_valid),
      .i_rr_ptr  (r_rr_ptr),
      .o_gnt     (w_gnt),
      .o_gnt_idx (w_gnt_idx)
   );

   assign w_any_req = |i_src_valid;
   // Reset gates the load so no source sees ready while the block is held.
   assign w_load    = i_reset_n && ((r_state == StEmpty) || i_out_ready) && w_any_req;

   // Output-register state.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= StEmpty;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Fill on any request; drain only when accepted with nothing to refill.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StEmpty: if (w_any_req) w_state_next = StFull;
         StFull:  if (i_out_ready && !w_any_req) w_state_next = StEmpty;
         default: w_state_next = StEmpty;
      endcase
   end

   // Handshake and status outputs.
   always_comb begin
      o_out_valid = (r_state == StFull);
      o_busy      = (r_state == StFull) || w_any_req;
      o_src_ready = w_load ? w_gnt : '0;
   end

   // Capture the winning word and advance the round-robin pointer past it.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_out_data <= '0;
         r_out_src  <= '0;
         r_rr_ptr   <= '0;
      end else if (w_load) begin
         r_out_data <= i_src_data[w_gnt_idx*DATA_W +: DATA_W];
         r_out_src  <= w_gnt_idx;
         if (RR_MODE != 0) begin
            r_rr_ptr <= (w_gnt_idx == SRC_W'(NUM_SRC - 1)) ? '0 : w_gnt_idx + SRC_W'(1);
         end
      end
   end

   assign o_out_data = r_out_data;
   assign o_out_src  = r_out_src;

`ifdef WB_BUS_CONFLICT_CNT_EN
   logic [31:0] r_conflict_cnt;
   logic        w_multi_req;

   // Clearing the lowest set bit leaves something only if two or more were set.
   assign w_multi_req = |(i_src_valid & (i_src_valid - 1'b1));

   // Saturating count of contended loads.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_conflict_cnt <= '0;
      end else if (w_load && w_multi_req && (r_conflict_cnt != 32'hFFFF_FFFF)) begin
         r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
   end

   assign o_conflict_cnt = r_conflict_cnt;
`endif

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: one round-robin and one fixed-priority instance
// share the same stimulus and are checked every cycle against a behavioural
// model, with directed literal expectations along the way.
module tb_wb_bus_arbiter;

   localparam int N  = 6;
   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [N-1:0]  src_valid = '1;
   logic [N*DW-1:0] src_data;
   logic          out_ready = 1'b1;

   logic [N-1:0]  rdy_rr, rdy_fp;
   logic          vld_rr, vld_fp;
   logic [DW-1:0] dat_rr, dat_fp;
   logic [2:0]    src_rr, src_fp;
   logic          busy_rr, busy_fp;
`ifdef WB_BUS_CONFLICT_CNT_EN
   logic [31:0]   cnt_rr, cnt_fp;
`endif

   int compared = 0;
   int mismatched = 0;

   always #5 clk = ~clk;

   wb_bus_arbiter #(.DATA_W(DW), .NUM_SRC(N), .RR_MODE(1)) dut_rr (
      .i_clk          (clk),
      .i_reset_n      (reset_n),
      .i_src_valid    (src_valid),
      .i_src_data     (src_data),
      .o_src_ready    (rdy_rr),
      .o_out_valid    (vld_rr),
      .o_out_data     (dat_rr),
      .o_out_src      (src_rr),
      .i_out_ready    (out_ready),
`ifdef WB_BUS_CONFLICT_CNT_EN
      .o_conflict_cnt (cnt_rr),
`endif
      .o_busy         (busy_rr)
   );

   wb_bus_arbiter #(.DATA_W(DW), .NUM_SRC(N), .RR_MODE(0)) dut_fp (
      .i_clk          (clk),
      .i_reset_n      (reset_n),
      .i_src_valid    (src_valid),
      .i_src_data     (src_data),
      .o_src_ready    (rdy_fp),
      .o_out_valid    (vld_fp),
      .o_out_data     (dat_fp),
      .o_out_src      (src_fp),
      .i_out_ready    (out_ready),
`ifdef WB_BUS_CONFLICT_CNT_EN
      .o_conflict_cnt (cnt_fp),
`endif
      .o_busy         (busy_fp)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state, index 1 = round-robin instance, 0 = fixed priority.
   bit            m_full[2] = '{0, 0};
   logic [DW-1:0] m_data[2] = '{16'h0, 16'h0};
   int            m_src[2]  = '{0, 0};
   int            m_ptr[2]  = '{0, 0};
   int unsigned   m_cnt[2]  = '{0, 0};

   function automatic int win(input logic [N-1:0] v, input int start);
      for (int k = 0; k < N; k++) begin
         if (v[(start + k) % N]) return (start + k) % N;
      end
      return -1;
   endfunction

   function automatic int popcnt(input logic [N-1:0] v);
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(v[i]);
      return c;
   endfunction

   function automatic bit loads(input int m);
      return reset_n && (!m_full[m] || out_ready) && (src_valid != '0);
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int m = 0; m < 2; m++) begin
            m_full[m] = 0; m_data[m] = '0; m_src[m] = 0; m_ptr[m] = 0; m_cnt[m] = 0;
         end
      end else begin
         for (int m = 0; m < 2; m++) begin
            int g;
            if (loads(m)) begin
               g = win(src_valid, (m == 1) ? m_ptr[m] : 0);
               if (popcnt(src_valid) >= 2 && m_cnt[m] != 32'hFFFF_FFFF) m_cnt[m]++;
               m_data[m] = src_data[g*DW +: DW];
               m_src[m]  = g;
               m_full[m] = 1;
               if (m == 1) m_ptr[m] = (g + 1) % N;
            end else if (m_full[m] && out_ready) begin
               m_full[m] = 0;
            end
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         logic [N-1:0] er;
         er = loads(m) ? (N'(1) << win(src_valid, (m == 1) ? m_ptr[m] : 0)) : '0;
         chk(m ? "rr.src_ready" : "fp.src_ready", m ? rdy_rr : rdy_fp, er);
         chk(m ? "rr.out_valid" : "fp.out_valid", m ? vld_rr : vld_fp, m_full[m]);
         chk(m ? "rr.out_data" : "fp.out_data", m ? dat_rr : dat_fp, m_data[m]);
         chk(m ? "rr.out_src" : "fp.out_src", m ? src_rr : src_fp, m_src[m]);
         chk(m ? "rr.busy" : "fp.busy", m ? busy_rr : busy_fp, m_full[m] || (src_valid != '0));
`ifdef WB_BUS_CONFLICT_CNT_EN
         chk(m ? "rr.conflict_cnt" : "fp.conflict_cnt", m ? cnt_rr : cnt_fp, m_cnt[m]);
`endif
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) src_data[i*DW +: DW] = 16'hA000 + 16'(i);

      // Reset held with every source requesting.
      repeat (3) @(posedge clk);
      #1;
      chk("rst.out_valid", vld_rr, 0);
      chk("rst.out_data", dat_rr, 0);
      chk("rst.src_ready_rr", rdy_rr, 0);
      chk("rst.src_ready_fp", rdy_fp, 0);
      reset_n = 1'b1;
      #1;
      chk("rel.src_ready", rdy_rr, 6'b000001);

      // Fairness: 0,1,2,3,4,5,0.
      for (int i = 0; i < 7; i++) begin
         step();
         chk("rr.seq_src", src_rr, i % 6);
         chk("rr.seq_data", dat_rr, 16'hA000 + 16'(i % 6));
         chk("fp.seq_src", src_fp, 0);
      end

      // Drain to empty.
      src_valid = '0;
      step();
      chk("drain.out_valid", vld_rr, 0);
      chk("drain.busy", busy_rr, 0);

      // Back-pressure with src 3 holding 0x1234.
      src_data[3*DW +: DW] = 16'h1234;
      src_valid = 6'b001000;
      out_ready = 1'b0;
      step();
      chk("bp.load_src", src_rr, 3);
      chk("bp.load_data", dat_rr, 16'h1234);
      src_valid = '0;
      for (int c = 0; c < 4; c++) begin
         if (c == 2) src_valid = 6'b000010;
         #1;
         chk("bp.src_ready", rdy_rr, 0);
         chk("bp.hold_data", dat_rr, 16'h1234);
         chk("bp.hold_valid", vld_rr, 1);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp.release_ready_rr", rdy_rr, 6'b000010);
      chk("bp.release_ready_fp", rdy_fp, 6'b000010);
      step();
      chk("bp.release_src", src_rr, 1);

      // Wrap-around: move pointer to 5 by granting 4.
      src_valid = 6'b010000;
      step();
      chk("wrap.src4", src_rr, 4);
      src_valid = 6'b100001;
      step();
      chk("wrap.src5", src_rr, 5);
      chk("wrap.fp0", src_fp, 0);
      step();
      chk("wrap.src0", src_rr, 0);
      src_valid = 6'b000100;
      step();
      chk("wrap.src2", src_rr, 2);
      src_valid = 6'b001001;
      step();
      chk("wrap.ptr3", src_rr, 3);
      chk("wrap.fp_low", src_fp, 0);

      // Fixed priority picks lowest index.
      src_valid = 6'b010110;
      repeat (3) begin
         step();
         chk("fp.pri1", src_fp, 1);
      end
      src_valid = 6'b010100;
      repeat (2) begin
         step();
         chk("fp.pri2", src_fp, 2);
      end

      // Reset asserted while holding a word under back-pressure.
      out_ready = 1'b0;
      step();
      reset_n = 1'b0;
      #1;
      chk("midrst.out_valid", vld_rr, 0);
      chk("midrst.out_data", dat_rr, 0);
      chk("midrst.src_ready", rdy_rr, 0);
      step();

      // Contention: 10 loads with 3 requesters, then 5 with one.
      reset_n = 1'b1;
      out_ready = 1'b1;
      src_valid = 6'b000111;
      repeat (10) step();
      src_valid = 6'b000001;
      repeat (5) step();
`ifdef WB_BUS_CONFLICT_CNT_EN
      chk("cnt.rr", cnt_rr, 10);
      chk("cnt.fp", cnt_fp, 10);
`endif
      chk("cnt.last_src", src_rr, 0);

      src_valid = '0;
      repeat (2) step();
      chk("idle.busy", busy_rr, 0);
      chk("idle.out_valid", vld_fp, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
